tpu_cmd_queue: RTL

- Host-side command front end for the TPU.
- Buffers 64-bit GEMM commands in a parametrised FIFO and assigns each a sequence tag.
- Issues commands to control_unit through its cmd_valid/cmd_ready port, with a limit on commands in flight.
- Matches completion pulses (control_unit done_irq) to tags in order, and coalesces completions into one host interrupt with count and timeout triggers, sticky until acknowledged.

---
 rtl/tpu_cmd_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tpu_cmd_queue.sv
// Host command front end: queues tagged GEMM commands, issues them to control_unit
// under an in-flight limit, and coalesces completions into a sticky host interrupt.
// Latency: an accepted command is offered to control_unit no earlier than the next cycle.
// Backpressure: host_cmd_ready is low when the queue is full or during flush/reset.
module tpu_cmd_queue #(
   parameter int CMD_WIDTH    = 64,
   parameter int DEPTH        = 4,
   parameter int MAX_INFLIGHT = 2,
   parameter int TAG_WIDTH    = 4,
   parameter int PEND_WIDTH   = 8,
   parameter int TMO_WIDTH    = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              host_cmd_valid,
   input  logic [CMD_WIDTH-1:0]              host_cmd_data,
   output logic                              host_cmd_ready,
   output logic [TAG_WIDTH-1:0]              host_cmd_tag,
   output logic                              cu_cmd_valid,
   output logic [CMD_WIDTH-1:0]              cu_cmd_data,
   input  logic                              cu_cmd_ready,
   input  logic                              cu_done,
   input  logic [PEND_WIDTH-1:0]             cfg_irq_threshold,
   input  logic [TMO_WIDTH-1:0]              cfg_irq_timeout,
   input  logic                              irq_ack,
   input  logic                              flush,
   output logic                              irq,
   output logic [PEND_WIDTH-1:0]             irq_pending_cnt,
   output logic [TAG_WIDTH-1:0]              done_tag,
   output logic [$clog2(DEPTH+1)-1:0]        fifo_level,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic                              busy,
   output logic                              err_spurious
);

   localparam int PW  = $clog2(DEPTH);
   localparam int IPW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int LW  = $clog2(DEPTH+1);
   localparam int IW  = $clog2(MAX_INFLIGHT+1);

   logic [CMD_WIDTH-1:0]  mem_dat_q [DEPTH];
   logic [TAG_WIDTH-1:0]  mem_tag_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic [TAG_WIDTH-1:0]  ift_tag_q [MAX_INFLIGHT];
   logic [IPW-1:0]        ift_wr_q, ift_rd_q;
   logic [IW-1:0]         inflight_q;
   logic [TAG_WIDTH-1:0]  next_tag_q, done_tag_q;
   logic [PEND_WIDTH-1:0] pending_q, pending_d, thr_eff;
   logic [TMO_WIDTH-1:0]  timer_q, timer_d;
   logic                  irq_q, irq_d, err_q;
   logic                  full, empty, push, issue, done_ok;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [IPW-1:0] inc_iptr(input logic [IPW-1:0] p);
      return (p == IPW'(MAX_INFLIGHT-1)) ? '0 : p + IPW'(1);
   endfunction

   assign full           = (level_q == LW'(DEPTH));
   assign empty          = (level_q == '0);
   assign host_cmd_ready = rst && !full && !flush;
   assign push           = host_cmd_valid && host_cmd_ready;
   assign cu_cmd_valid   = !empty && (inflight_q < IW'(MAX_INFLIGHT)) && !flush;
   assign issue          = cu_cmd_valid && cu_cmd_ready;
   assign done_ok        = cu_done && (inflight_q != '0);
   assign thr_eff        = (cfg_irq_threshold == '0) ? PEND_WIDTH'(1) : cfg_irq_threshold;

   assign host_cmd_tag    = next_tag_q;
   assign cu_cmd_data     = mem_dat_q[rd_ptr_q];
   assign irq             = irq_q;
   assign irq_pending_cnt = pending_q;
   assign done_tag        = done_tag_q;
   assign fifo_level      = level_q;
   assign inflight        = inflight_q;
   assign busy            = (level_q != '0) || (inflight_q != '0);
   assign err_spurious    = err_q;

   // Command and tag storage; occupancy is tracked by level_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dat_q[wr_ptr_q] <= host_cmd_data;
         mem_tag_q[wr_ptr_q] <= next_tag_q;
      end
   end

   // Coalescing next state: ack wins over triggers, triggers look at next pending/timer.
   always_comb begin
      pending_d = pending_q;
      timer_d   = timer_q;
      irq_d     = irq_q;
      if (irq_ack) begin
         pending_d = done_ok ? PEND_WIDTH'(1) : '0;
         timer_d   = '0;
         irq_d     = 1'b0;
      end else begin
         if (done_ok && (pending_q != '1)) pending_d = pending_q + PEND_WIDTH'(1);
         if (done_ok) timer_d = '0;
         else if ((pending_q != '0) && !irq_q) timer_d = timer_q + TMO_WIDTH'(1);
         if (pending_d >= thr_eff) irq_d = 1'b1;
         if ((cfg_irq_timeout != '0) && (pending_d != '0) &&
             (timer_d == cfg_irq_timeout - TMO_WIDTH'(1))) irq_d = 1'b1;
      end
   end

   // Queue pointers, in-flight tag tracking, tags, and interrupt state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ift_wr_q   <= '0;
         ift_rd_q   <= '0;
         inflight_q <= '0;
         next_tag_q <= '0;
         done_tag_q <= '1;
         pending_q  <= '0;
         timer_q    <= '0;
         irq_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
         end else begin
            if (push)  wr_ptr_q <= inc_ptr(wr_ptr_q);
            if (issue) rd_ptr_q <= inc_ptr(rd_ptr_q);
            case ({push, issue})
               2'b10:   level_q <= level_q + LW'(1);
               2'b01:   level_q <= level_q - LW'(1);
               default: level_q <= level_q;
            endcase
         end
         if (push) next_tag_q <= next_tag_q + TAG_WIDTH'(1);
         if (issue) begin
            ift_tag_q[ift_wr_q] <= mem_tag_q[rd_ptr_q];
            ift_wr_q            <= inc_iptr(ift_wr_q);
         end
         if (done_ok) begin
            done_tag_q <= ift_tag_q[ift_rd_q];
            ift_rd_q   <= inc_iptr(ift_rd_q);
         end
         case ({issue, done_ok})
            2'b10:   inflight_q <= inflight_q + IW'(1);
            2'b01:   inflight_q <= inflight_q - IW'(1);
            default: inflight_q <= inflight_q;
         endcase
         if (cu_done && (inflight_q == '0)) err_q <= 1'b1;
         pending_q <= pending_d;
         timer_q   <= timer_d;
         irq_q     <= irq_d;
      end
   end

endmodule
